// File: rtl/board_update_arbiter.sv
// ============================================================================
// Module      : board_update_arbiter
// Description : Owns the 8x8 piece board shown by screen_gen and applies queued
//               game-logic edits only during vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_update_arbiter #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [9:0]            vcount,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [5:0]            req_src,
  input  logic [5:0]            req_dst,
  input  logic [3:0]            req_piece,
  output logic [7:0][7:0][3:0]  board,
  output logic                  pending,
  output logic                  frame_commit
);

  localparam int          AW            = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_depth       = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] c_one         = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one   = AW'(1);
  localparam logic [9:0]  c_vblank_line = 10'(SCREEN_HEIGHT);
  localparam logic [3:0]  c_empty       = 4'hF;
  localparam logic [1:0]  c_op_set      = 2'b00;
  localparam logic [1:0]  c_op_clear    = 2'b01;
  localparam logic [1:0]  c_op_move     = 2'b10;
  localparam logic [1:0]  c_op_reset    = 2'b11;

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  // Concatenations list column 7 first, so the back ranks read right-to-left.
  function automatic logic [7:0][7:0][3:0] initial_layout();
    logic [7:0][7:0][3:0] b;
    b    = {64{c_empty}};
    b[0] = {4'd9, 4'd7, 4'd8, 4'd11, 4'd10, 4'd8, 4'd7, 4'd9};
    b[1] = {8{4'd6}};
    b[6] = {8{4'd0}};
    b[7] = {4'd3, 4'd1, 4'd2, 4'd5, 4'd4, 4'd2, 4'd1, 4'd3};
    return b;
  endfunction

  state_t          r_state;
  logic            r_applied;
  logic [17:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_next;
  logic            w_vblank;
  logic            w_push;
  logic            w_pop;
  logic [17:0]     w_entry;
  logic [1:0]      w_op;
  logic [5:0]      w_src;
  logic [5:0]      w_dst;
  logic [3:0]      w_piece;

  assign w_vblank = (vcount >= c_vblank_line);
  assign w_push   = req_valid && req_ready;
  assign w_pop    = (r_state == DRAIN) && w_vblank && (r_count != '0);
  assign pending  = (r_count != '0);

  assign w_entry  = r_mem[r_rd_ptr];
  assign w_op     = w_entry[17:16];
  assign w_src    = w_entry[15:10];
  assign w_dst    = w_entry[9:4];
  assign w_piece  = w_entry[3:0];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + c_one;
    else if (!w_push && w_pop)
      w_count_next = r_count - c_one;
  end

  always_ff @(posedge vga_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {req_op, req_src, req_dst, req_piece};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      req_ready <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_count   <= w_count_next;
      req_ready <= (w_count_next != c_depth);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_applied    <= 1'b0;
      frame_commit <= 1'b0;
      board        <= initial_layout();
    end else begin
      frame_commit <= 1'b0;
      case (r_state)
        IDLE: begin
          r_applied <= 1'b0;
          if (w_vblank)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_vblank) begin
            r_state      <= IDLE;
            frame_commit <= r_applied;
          end else if (w_pop) begin
            r_applied <= 1'b1;
            case (w_op)
              c_op_set:   board[w_dst[5:3]][w_dst[2:0]] <= w_piece;
              c_op_clear: board[w_dst[5:3]][w_dst[2:0]] <= c_empty;
              c_op_move: begin
                // A self-move must leave the piece in place, not blank it.
                if (w_src != w_dst) begin
                  board[w_dst[5:3]][w_dst[2:0]] <= board[w_src[5:3]][w_src[2:0]];
                  board[w_src[5:3]][w_src[2:0]] <= c_empty;
                end
              end
              c_op_reset: board <= initial_layout();
              default:    board <= board;
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_board_update_arbiter.sv
// ============================================================================
// Module      : tb_board_update_arbiter
// Description : Directed self-checking bench for board_update_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_update_arbiter;

  typedef logic [7:0][7:0][3:0] board_t;

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  logic       vga_clk;
  logic       reset_n;
  logic [9:0] vcount;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [5:0] req_src;
  logic [5:0] req_dst;
  logic [3:0] req_piece;
  board_t     board;
  logic       pending;
  logic       frame_commit;

  int     checks = 0;
  int     passed = 0;
  int     fc_seen;
  board_t exp_b;

  board_update_arbiter #(.SCREEN_HEIGHT(480), .FIFO_DEPTH(8)) dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .vcount       (vcount),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .req_piece    (req_piece),
    .board        (board),
    .pending      (pending),
    .frame_commit (frame_commit)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic board_t init_b();
    board_t b;
    b = {64{4'hF}};
    for (int c = 0; c < 8; c++) begin
      b[1][c] = 4'd6;
      b[6][c] = 4'd0;
    end
    b[0][0] = 4'd9;  b[0][1] = 4'd7; b[0][2] = 4'd8; b[0][3] = 4'd10;
    b[0][4] = 4'd11; b[0][5] = 4'd8; b[0][6] = 4'd7; b[0][7] = 4'd9;
    b[7][0] = 4'd3;  b[7][1] = 4'd1; b[7][2] = 4'd2; b[7][3] = 4'd4;
    b[7][4] = 4'd5;  b[7][5] = 4'd2; b[7][6] = 4'd1; b[7][7] = 4'd3;
    return b;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [5:0] src,
                      input logic [5:0] dst, input logic [3:0] piece);
    req_valid = 1'b1;
    req_op    = op;
    req_src   = src;
    req_dst   = dst;
    req_piece = piece;
    tick(1);
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    vcount    = 10'd0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src   = 6'd0;
    req_dst   = 6'd0;
    req_piece = 4'd0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    exp_b = init_b();
    check("reset_board", board, exp_b);
    check("reset_b74", board[7][4], 4'd5);
    check("reset_b03", board[0][3], 4'd10);
    check("reset_ready", req_ready, 1'b1);
    check("reset_pending", pending, 1'b0);
    check("reset_commit", frame_commit, 1'b0);

    // MOVE queued in active video, applied one cycle after DRAIN entry
    vcount = 10'd100;
    push(OP_MOVE, 6'd52, 6'd36, 4'd0);
    check("move_pending", pending, 1'b1);
    tick(3);
    check("move_active_hold", board, exp_b);
    vcount = 10'd480;
    tick(1);
    check("move_entry_hold", board, exp_b);
    tick(1);
    exp_b[4][4] = 4'h0;
    exp_b[6][4] = 4'hF;
    check("move_applied", board, exp_b);
    check("move_pending_clear", pending, 1'b0);
    tick(1);
    check("move_no_early_commit", frame_commit, 1'b0);
    vcount = 10'd0;
    tick(1);
    check("move_commit_pulse", frame_commit, 1'b1);
    tick(1);
    check("move_commit_single", frame_commit, 1'b0);

    // Fill the FIFO: 8 accepted, 9th stalls until the first blanking pop
    vcount = 10'd100;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_op    = OP_SET;
      req_dst   = 6'(24 + i);
      req_piece = 4'(i);
      check("fill_ready", req_ready, 1'b1);
      tick(1);
    end
    check("full_ready_low", req_ready, 1'b0);
    req_dst   = 6'd32;
    req_piece = 4'd8;
    tick(2);
    check("full_stall", req_ready, 1'b0);
    check("full_board_hold", board, exp_b);
    vcount = 10'd480;
    tick(1);
    check("full_entry_ready", req_ready, 1'b0);
    tick(1);
    exp_b[3][0] = 4'd0;
    check("full_pop0", board, exp_b);
    check("full_ready_rise", req_ready, 1'b1);
    tick(1);
    req_valid = 1'b0;
    exp_b[3][1] = 4'd1;
    check("full_pop1", board, exp_b);
    check("full_pending", pending, 1'b1);
    tick(7);
    for (int i = 2; i < 8; i++) exp_b[3][i] = 4'(i);
    exp_b[4][0] = 4'd8;
    check("full_all_applied", board, exp_b);
    check("full_drained", pending, 1'b0);
    vcount = 10'd0;
    tick(1);
    check("full_commit", frame_commit, 1'b1);
    tick(1);

    // Short blanking: entry edge plus three drain edges apply exactly three ops
    vcount = 10'd100;
    for (int i = 0; i < 6; i++) push(OP_CLEAR, 6'd0, 6'(56 + i), 4'd0);
    vcount = 10'd480;
    tick(4);
    vcount = 10'd0;
    tick(1);
    exp_b[7][0] = 4'hF;
    exp_b[7][1] = 4'hF;
    exp_b[7][2] = 4'hF;
    check("short_three_applied", board, exp_b);
    check("short_pending", pending, 1'b1);
    check("short_commit", frame_commit, 1'b1);
    tick(2);
    check("short_active_hold", board, exp_b);
    vcount = 10'd480;
    tick(2);
    exp_b[7][3] = 4'hF;
    check("short_resume_order", board, exp_b);
    tick(2);
    exp_b[7][4] = 4'hF;
    exp_b[7][5] = 4'hF;
    check("short_resume_done", board, exp_b);
    check("short_drained", pending, 1'b0);
    vcount = 10'd0;
    tick(2);

    // SET, RESET_BOARD, CLEAR in one blanking
    vcount = 10'd100;
    push(OP_SET, 6'd0, 6'd27, 4'd4);
    push(OP_RESET, 6'd0, 6'd0, 4'd0);
    push(OP_CLEAR, 6'd0, 6'd0, 4'd0);
    vcount = 10'd480;
    tick(2);
    check("seq_set_applied", board[3][3], 4'd4);
    tick(2);
    exp_b = init_b();
    exp_b[0][0] = 4'hF;
    check("seq_final_board", board, exp_b);
    check("seq_b33_empty", board[3][3], 4'hF);
    vcount = 10'd0;
    tick(2);

    // Asynchronous reset in the middle of a drain
    vcount = 10'd100;
    for (int i = 0; i < 4; i++) push(OP_CLEAR, 6'd0, 6'(8 + i), 4'd0);
    vcount = 10'd480;
    tick(2);
    exp_b[1][0] = 4'hF;
    check("rst_mid_drain", board, exp_b);
    #3;
    reset_n = 1'b0;
    #1;
    exp_b = init_b();
    check("rst_async_board", board, exp_b);
    check("rst_async_pending", pending, 1'b0);
    check("rst_async_ready", req_ready, 1'b1);
    tick(1);
    reset_n = 1'b1;
    fc_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (frame_commit) fc_seen++;
    end
    check("rst_queue_discarded", board, exp_b);
    vcount = 10'd0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (frame_commit) fc_seen++;
    end
    check("rst_no_commit", fc_seen, 0);
    check("rst_pending_after", pending, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
